// File: rtl/data_mem_access_unit_if.sv
// Bundle of CPU request/response and RAM port signals for data_mem_access_unit.
// ram_be exists only when MEMACC_BYTE_WE_EN is defined.
interface data_mem_access_unit_if #(
  parameter int RAM_AW  = 9,
  parameter int PADDR_W = RAM_AW + 2
);
  logic               req_valid;
  logic               req_ready;
  logic               mem_write;
  logic [1:0]         size;
  logic               sign_ext;
  logic [PADDR_W-1:0] pAddr;
  logic               iAddr;
  logic [31:0]        wdata;
  logic               resp_valid;
  logic               resp_ready;
  logic [31:0]        rdata;
  logic               addr_err;
  logic [RAM_AW-1:0]  ram_addr;
  logic               ram_we;
  logic [31:0]        ram_wdata;
  logic [31:0]        ram_rdata;
`ifdef MEMACC_BYTE_WE_EN
  logic [3:0]         ram_be;
`endif

  modport slave (
    input  req_valid, mem_write, size, sign_ext, pAddr, iAddr, wdata,
    input  resp_ready, ram_rdata,
    output req_ready, resp_valid, rdata, addr_err, ram_addr, ram_we, ram_wdata
`ifdef MEMACC_BYTE_WE_EN
    , output ram_be
`endif
  );

  modport master (
    output req_valid, mem_write, size, sign_ext, pAddr, iAddr, wdata,
    output resp_ready, ram_rdata,
    input  req_ready, resp_valid, rdata, addr_err, ram_addr, ram_we, ram_wdata
`ifdef MEMACC_BYTE_WE_EN
    , input ram_be
`endif
  );
endinterface

// File: rtl/data_mem_access_unit.sv
// Load/store engine between the address decoder and a 512x32 synchronous RAM.
// Define MEMACC_BYTE_WE_EN for per-byte RAM write enables instead of read-modify-write.
module data_mem_access_unit #(
  parameter int RAM_AW  = 9,
  parameter int PADDR_W = RAM_AW + 2
) (
  input logic                   clk,
  input logic                   rst_n,
  data_mem_access_unit_if.slave bus
);

  localparam logic [2:0] IDLE  = 3'd0;
  localparam logic [2:0] READ  = 3'd1;
  localparam logic [2:0] MERGE = 3'd2;
  localparam logic [2:0] WRITE = 3'd3;
  localparam logic [2:0] LOAD  = 3'd4;
  localparam logic [2:0] RESP  = 3'd5;

  logic [2:0]        state_q, state_d;
  logic [1:0]        off_q, off_d;
  logic [1:0]        size_q, size_d;
  logic              sign_q, sign_d;
  logic              we_q, we_d;
  logic [15:0]       wdata_q, wdata_d;
  logic              resp_valid_q, resp_valid_d;
  logic [31:0]       rdata_q, rdata_d;
  logic              addr_err_q, addr_err_d;
  logic [RAM_AW-1:0] ram_addr_q, ram_addr_d;
  logic              ram_we_q, ram_we_d;
  logic [31:0]       ram_wdata_q, ram_wdata_d;
`ifdef MEMACC_BYTE_WE_EN
  logic [3:0]        ram_be_q, ram_be_d;
`endif

  logic              acc_err;
  logic [31:0]       byte_lane, half_lane, load_val, merged;

  assign acc_err = bus.iAddr || (bus.size == 2'b11)
                || (bus.size == 2'b01 && bus.pAddr[0])
                || (bus.size == 2'b10 && bus.pAddr[1:0] != 2'b00);

  // Lane extraction and merge both work on the word the RAM returns this cycle
  always_comb begin
    byte_lane = bus.ram_rdata >> {off_q, 3'b000};
    half_lane = bus.ram_rdata >> {off_q[1], 4'b0000};
    case (size_q)
      2'b00:   load_val = sign_q ? {{24{byte_lane[7]}}, byte_lane[7:0]} : {24'h0, byte_lane[7:0]};
      2'b01:   load_val = sign_q ? {{16{half_lane[15]}}, half_lane[15:0]} : {16'h0, half_lane[15:0]};
      default: load_val = bus.ram_rdata;
    endcase
    merged = bus.ram_rdata;
    if (size_q == 2'b00) merged[{off_q, 3'b000} +: 8] = wdata_q[7:0];
    else                 merged[{off_q[1], 4'b0000} +: 16] = wdata_q;
  end

  always_comb begin
    state_d      = state_q;
    off_d        = off_q;
    size_d       = size_q;
    sign_d       = sign_q;
    we_d         = we_q;
    wdata_d      = wdata_q;
    resp_valid_d = resp_valid_q;
    rdata_d      = rdata_q;
    addr_err_d   = addr_err_q;
    ram_addr_d   = ram_addr_q;
    ram_we_d     = ram_we_q;
    ram_wdata_d  = ram_wdata_q;
`ifdef MEMACC_BYTE_WE_EN
    ram_be_d     = ram_be_q;
`endif
    case (state_q)
      IDLE: begin
        if (bus.req_valid) begin
          off_d      = bus.pAddr[1:0];
          size_d     = bus.size;
          sign_d     = bus.sign_ext;
          we_d       = bus.mem_write;
          wdata_d    = bus.wdata[15:0];
          rdata_d    = 32'h0;
          addr_err_d = 1'b0;
          ram_addr_d = bus.pAddr[PADDR_W-1:2];
          if (acc_err) begin
            addr_err_d   = 1'b1;
            resp_valid_d = 1'b1;
            state_d      = RESP;
`ifdef MEMACC_BYTE_WE_EN
          end else if (bus.mem_write) begin
            ram_we_d = 1'b1;
            state_d  = WRITE;
            case (bus.size)
              2'b00: begin
                ram_wdata_d = {4{bus.wdata[7:0]}};
                ram_be_d    = 4'b0001 << bus.pAddr[1:0];
              end
              2'b01: begin
                ram_wdata_d = {2{bus.wdata[15:0]}};
                ram_be_d    = bus.pAddr[1] ? 4'b1100 : 4'b0011;
              end
              default: begin
                ram_wdata_d = bus.wdata;
                ram_be_d    = 4'b1111;
              end
            endcase
`else
          end else if (bus.mem_write && bus.size == 2'b10) begin
            ram_we_d    = 1'b1;
            ram_wdata_d = bus.wdata;
            state_d     = WRITE;
`endif
          end else begin
            state_d = READ;
          end
        end
      end
      READ:  state_d = we_q ? MERGE : LOAD;
      MERGE: begin
        ram_wdata_d = merged;
        ram_we_d    = 1'b1;
        state_d     = WRITE;
      end
      WRITE: begin
        ram_we_d     = 1'b0;
        resp_valid_d = 1'b1;
        state_d      = RESP;
      end
      LOAD: begin
        rdata_d      = load_val;
        resp_valid_d = 1'b1;
        state_d      = RESP;
      end
      RESP: begin
        if (bus.resp_ready) begin
          resp_valid_d = 1'b0;
          state_d      = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q      <= IDLE;
      off_q        <= 2'b00;
      size_q       <= 2'b00;
      sign_q       <= 1'b0;
      we_q         <= 1'b0;
      wdata_q      <= 16'h0;
      resp_valid_q <= 1'b0;
      rdata_q      <= 32'h0;
      addr_err_q   <= 1'b0;
      ram_addr_q   <= '0;
      ram_we_q     <= 1'b0;
      ram_wdata_q  <= 32'h0;
`ifdef MEMACC_BYTE_WE_EN
      ram_be_q     <= 4'h0;
`endif
    end else begin
      state_q      <= state_d;
      off_q        <= off_d;
      size_q       <= size_d;
      sign_q       <= sign_d;
      we_q         <= we_d;
      wdata_q      <= wdata_d;
      resp_valid_q <= resp_valid_d;
      rdata_q      <= rdata_d;
      addr_err_q   <= addr_err_d;
      ram_addr_q   <= ram_addr_d;
      ram_we_q     <= ram_we_d;
      ram_wdata_q  <= ram_wdata_d;
`ifdef MEMACC_BYTE_WE_EN
      ram_be_q     <= ram_be_d;
`endif
    end
  end

  assign bus.req_ready  = (state_q == IDLE);
  assign bus.resp_valid = resp_valid_q;
  assign bus.rdata      = rdata_q;
  assign bus.addr_err   = addr_err_q;
  assign bus.ram_addr   = ram_addr_q;
  assign bus.ram_we     = ram_we_q;
  assign bus.ram_wdata  = ram_wdata_q;
`ifdef MEMACC_BYTE_WE_EN
  assign bus.ram_be     = ram_be_q;
`endif

endmodule

// File: tb/tb_data_mem_access_unit.sv
// Directed bench for data_mem_access_unit with a behavioural 512x32 synchronous RAM.
// Expected sub-word store behaviour follows MEMACC_BYTE_WE_EN when it is defined.
module tb_data_mem_access_unit;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   compared = 0;
  int   mismatched = 0;
  int   we_pulses = 0;
  logic [8:0]  last_we_addr = '0;
  logic [31:0] last_we_data = '0;
  logic [3:0]  last_we_be = '0;
  logic [31:0] mem [512];
  logic        bd_we = 1'b0;
  logic [8:0]  bd_addr = '0;
  logic [31:0] bd_data = '0;

`ifdef MEMACC_BYTE_WE_EN
  localparam int SUBW_LAT = 2;
`else
  localparam int SUBW_LAT = 4;
`endif

  data_mem_access_unit_if #(.RAM_AW(9), .PADDR_W(11)) bus ();

  data_mem_access_unit #(.RAM_AW(9), .PADDR_W(11)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  // RAM model plus backdoor preload port and a write-pulse recorder
  always @(posedge clk) begin
    if (bd_we) mem[bd_addr] <= bd_data;
    if (bus.ram_we) begin
`ifdef MEMACC_BYTE_WE_EN
      for (int i = 0; i < 4; i++)
        if (bus.ram_be[i]) mem[bus.ram_addr][8*i +: 8] <= bus.ram_wdata[8*i +: 8];
      last_we_be = bus.ram_be;
`else
      mem[bus.ram_addr] <= bus.ram_wdata;
      last_we_be = 4'hF;
`endif
      we_pulses++;
      last_we_addr = bus.ram_addr;
      last_we_data = bus.ram_wdata;
    end
    bus.ram_rdata <= mem[bus.ram_addr];
  end

  task automatic check_output(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    compared++;
    assert (obs === exp) else begin
      mismatched++;
      $error("[TB] FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  task automatic preload(input logic [8:0] a, input logic [31:0] d);
    bd_we = 1'b1; bd_addr = a; bd_data = d;
    @(negedge clk);
    bd_we = 1'b0;
  endtask

  // One request, then scrambled inputs, bounded wait, optional stall, handshake
  task automatic apply_stimulus(input string tag, input logic wr, input logic [1:0] sz,
                                input logic sx, input logic [10:0] a, input logic ia,
                                input logic [31:0] wd, input int exp_lat,
                                input logic [31:0] exp_rdata, input logic exp_err,
                                input int exp_pulses, input int stall);
    int lat;
    int p0;
    check_output({tag, ".req_ready"}, 32'(bus.req_ready), 32'd1);
    p0 = we_pulses;
    bus.mem_write = wr; bus.size = sz; bus.sign_ext = sx;
    bus.pAddr = a; bus.iAddr = ia; bus.wdata = wd; bus.req_valid = 1'b1;
    @(negedge clk);
    bus.req_valid = 1'b0;
    bus.pAddr = 11'($urandom); bus.size = 2'($urandom); bus.wdata = $urandom;
    bus.sign_ext = ~sx; bus.mem_write = ~wr; bus.iAddr = 1'($urandom);
    lat = 1;
    while (!bus.resp_valid && lat < 12) begin
      @(negedge clk);
      lat++;
    end
    check_output({tag, ".latency"}, 32'(lat), 32'(exp_lat));
    check_output({tag, ".rdata"}, bus.rdata, exp_rdata);
    check_output({tag, ".addr_err"}, 32'(bus.addr_err), 32'(exp_err));
    for (int i = 0; i < stall; i++) begin
      @(negedge clk);
      check_output({tag, ".stall_valid"}, 32'(bus.resp_valid), 32'd1);
      check_output({tag, ".stall_rdata"}, bus.rdata, exp_rdata);
      check_output({tag, ".stall_ready"}, 32'(bus.req_ready), 32'd0);
    end
    bus.resp_ready = 1'b1;
    @(negedge clk);
    bus.resp_ready = 1'b0;
    check_output({tag, ".resp_drop"}, 32'(bus.resp_valid), 32'd0);
    check_output({tag, ".ready_again"}, 32'(bus.req_ready), 32'd1);
    check_output({tag, ".we_pulses"}, 32'(we_pulses - p0), 32'(exp_pulses));
  endtask

  initial begin
    int p0;
    bus.req_valid = 1'b0; bus.mem_write = 1'b0; bus.size = 2'b00; bus.sign_ext = 1'b0;
    bus.pAddr = '0; bus.iAddr = 1'b0; bus.wdata = '0; bus.resp_ready = 1'b0;
    @(negedge clk);
    @(negedge clk);
    check_output("rst.resp_valid", 32'(bus.resp_valid), 32'd0);
    check_output("rst.rdata", bus.rdata, 32'h0);
    check_output("rst.addr_err", 32'(bus.addr_err), 32'd0);
    check_output("rst.ram_we", 32'(bus.ram_we), 32'd0);
    check_output("rst.ram_addr", 32'(bus.ram_addr), 32'd0);
    check_output("rst.ram_wdata", bus.ram_wdata, 32'h0);
`ifdef MEMACC_BYTE_WE_EN
    check_output("rst.ram_be", 32'(bus.ram_be), 32'd0);
`endif
    rst_n = 1'b1;
    @(negedge clk);
    check_output("rst.req_ready", 32'(bus.req_ready), 32'd1);

    preload(9'd1, 32'h8899AABB);
    apply_stimulus("lw4",  1'b0, 2'b10, 1'b0, 11'h004, 1'b0, 32'h0, 3, 32'h8899AABB, 1'b0, 0, 0);
    apply_stimulus("lb5",  1'b0, 2'b00, 1'b1, 11'h005, 1'b0, 32'h0, 3, 32'hFFFFFFAA, 1'b0, 0, 0);
    apply_stimulus("lbu5", 1'b0, 2'b00, 1'b0, 11'h005, 1'b0, 32'h0, 3, 32'h000000AA, 1'b0, 0, 0);
    apply_stimulus("lhu6", 1'b0, 2'b01, 1'b0, 11'h006, 1'b0, 32'h0, 3, 32'h00008899, 1'b0, 0, 0);
    apply_stimulus("lh6",  1'b0, 2'b01, 1'b1, 11'h006, 1'b0, 32'h0, 3, 32'hFFFF8899, 1'b0, 0, 0);
    apply_stimulus("lb4",  1'b0, 2'b00, 1'b1, 11'h004, 1'b0, 32'h0, 3, 32'hFFFFFFBB, 1'b0, 0, 0);

    apply_stimulus("sb6", 1'b1, 2'b00, 1'b0, 11'h006, 1'b0, 32'h00000011, SUBW_LAT, 32'h0, 1'b0, 1, 0);
    check_output("sb6.we_addr", 32'(last_we_addr), 32'd1);
`ifdef MEMACC_BYTE_WE_EN
    check_output("sb6.we_data", last_we_data, 32'h11111111);
    check_output("sb6.we_be", 32'(last_we_be), 32'h4);
`else
    check_output("sb6.we_data", last_we_data, 32'h8811AABB);
`endif
    apply_stimulus("lw4b", 1'b0, 2'b10, 1'b0, 11'h004, 1'b0, 32'h0, 3, 32'h8811AABB, 1'b0, 0, 0);

    apply_stimulus("sw8", 1'b1, 2'b10, 1'b0, 11'h008, 1'b0, 32'hDEADBEEF, 2, 32'h0, 1'b0, 1, 0);
    check_output("sw8.we_data", last_we_data, 32'hDEADBEEF);
    check_output("sw8.we_be", 32'(last_we_be), 32'hF);
    apply_stimulus("shA", 1'b1, 2'b01, 1'b0, 11'h00A, 1'b0, 32'hFFFF1234, SUBW_LAT, 32'h0, 1'b0, 1, 0);
`ifdef MEMACC_BYTE_WE_EN
    check_output("shA.we_data", last_we_data, 32'h12341234);
    check_output("shA.we_be", 32'(last_we_be), 32'hC);
`else
    check_output("shA.we_data", last_we_data, 32'h1234BEEF);
`endif
    apply_stimulus("lw8", 1'b0, 2'b10, 1'b0, 11'h008, 1'b0, 32'h0, 3, 32'h1234BEEF, 1'b0, 0, 0);

    apply_stimulus("err_lw2",   1'b0, 2'b10, 1'b0, 11'h002, 1'b0, 32'h0, 1, 32'h0, 1'b1, 0, 0);
    apply_stimulus("err_sh7ff", 1'b1, 2'b01, 1'b0, 11'h7FF, 1'b0, 32'h5555, 1, 32'h0, 1'b1, 0, 0);
    apply_stimulus("err_iaddr", 1'b0, 2'b10, 1'b0, 11'h010, 1'b1, 32'h0, 1, 32'h0, 1'b1, 0, 0);
    apply_stimulus("err_size3", 1'b1, 2'b11, 1'b0, 11'h000, 1'b0, 32'h77, 1, 32'h0, 1'b1, 0, 0);

    apply_stimulus("stall", 1'b0, 2'b10, 1'b0, 11'h004, 1'b0, 32'h0, 3, 32'h8811AABB, 1'b0, 0, 5);

`ifndef MEMACC_BYTE_WE_EN
    preload(9'd3, 32'hCAFEF00D);
    p0 = we_pulses;
    bus.mem_write = 1'b1; bus.size = 2'b00; bus.sign_ext = 1'b0;
    bus.pAddr = 11'h00C; bus.iAddr = 1'b0; bus.wdata = 32'h55; bus.req_valid = 1'b1;
    @(negedge clk);
    bus.req_valid = 1'b0;
    @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    check_output("rstm.resp_valid", 32'(bus.resp_valid), 32'd0);
    check_output("rstm.ram_we", 32'(bus.ram_we), 32'd0);
    check_output("rstm.ram_addr", 32'(bus.ram_addr), 32'd0);
    check_output("rstm.ram_wdata", bus.ram_wdata, 32'h0);
    check_output("rstm.rdata", bus.rdata, 32'h0);
    rst_n = 1'b1;
    @(negedge clk);
    @(negedge clk);
    @(negedge clk);
    check_output("rstm.we_pulses", 32'(we_pulses - p0), 32'd0);
    check_output("rstm.mem3", mem[3], 32'hCAFEF00D);
    check_output("rstm.req_ready", 32'(bus.req_ready), 32'd1);
    check_output("rstm.resp_after", 32'(bus.resp_valid), 32'd0);
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
